snk_packet_writer: RTL and testbench

- Avalon-ST sink front end of the sort path.
- Accepts one packet of up to MAX_LENGTH words and writes the words into the shared FIFO. It then raises snk_done for the downstream read/sort/source FSM.
- Holds off the next packet until the downstream stage has drained the FIFO and returned to idle (src_ready high).
- Enforces packet framing, truncates overlength packets and closes stalled packets on timeout.

---
 rtl/snk_packet_writer_pkg.sv | 17 +
 rtl/snk_packet_writer_pkt_timeout_cnt.sv | 30 +++
 rtl/snk_packet_writer.sv | 113 +++++++++++
 tb/tb_snk_packet_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snk_packet_writer_pkg.sv
// Shared definitions for the sort path: FSM state encodings and packet-length width.
// Also used by the downstream read/sort/source FSM so both sides agree on encodings.
package snk_packet_writer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DONE    = 2'd2,
    WAIT_DS = 2'd3
  } state_t;

  // Wide enough to hold the count MAX_LENGTH itself, not just MAX_LENGTH-1.
  function automatic int len_w(input int max_length);
    return $clog2(max_length + 1);
  endfunction

endpackage

// File: rtl/snk_packet_writer_pkt_timeout_cnt.sv
// Idle-cycle counter for an open packet; expire is combinational on the idle cycle seen with count TIMEOUT-1.
// No backpressure: clear wins over enable, TIMEOUT of 0 never expires.
module snk_packet_writer_pkt_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic src_clock,
  input  logic src_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  assign expire = (TIMEOUT > 0) && enable && (cnt == LAST);

  always_ff @(posedge src_clock or posedge src_reset) begin
    if (src_reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snk_packet_writer.sv
// Avalon-ST sink front end: frames one packet into the shared FIFO, zero-latency write path, snk_done one cycle after eop.
// Backpressure: snk_ready low on fifo_full, while DONE/WAIT_DS, and in IDLE until the downstream reports idle.
module snk_packet_writer
  import snk_packet_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  parameter int TIMEOUT    = 256,
  localparam int LEN_W     = len_w(MAX_LENGTH)
) (
  input  logic                  src_clock,
  input  logic                  src_reset,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic [DATA_WIDTH-1:0] snk_data,
  output logic                  snk_ready,
  input  logic                  fifo_full,
  output logic                  wr_fifo,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  src_ready,
  output logic                  snk_done,
  output logic [LEN_W-1:0]      pkt_len,
  output logic                  pkt_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LENGTH);

  state_t state;
  logic   accept;
  logic   write_en;
  logic   expire;

  // Gated by reset so nothing is taken while the FIFO owner is also clearing.
  assign snk_ready  = !src_reset && !fifo_full &&
                      (((state == IDLE) && src_ready) || (state == RECV));
  assign accept     = snk_valid && snk_ready;
  assign wr_fifo    = accept && write_en;
  assign fifo_wdata = snk_data;

  always_comb begin
    write_en = 1'b0;
    case (state)
      IDLE:    write_en = snk_sop;
      RECV:    write_en = (pkt_len < MAX_LEN);
      default: write_en = 1'b0;
    endcase
  end

  snk_packet_writer_pkt_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .src_clock (src_clock),
    .src_reset (src_reset),
    .clear     ((state != RECV) || accept),
    .enable    ((state == RECV) && !accept),
    .expire    (expire)
  );

  always_ff @(posedge src_clock or posedge src_reset) begin
    if (src_reset) begin
      state    <= IDLE;
      pkt_len  <= '0;
      pkt_err  <= 1'b0;
      snk_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && snk_sop) begin
            pkt_len <= LEN_W'(1);
            pkt_err <= 1'b0;
            if (snk_eop) begin
              state    <= DONE;
              snk_done <= 1'b1;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (accept) begin
            // Overlength words are dropped and the length saturates.
            if (pkt_len < MAX_LEN) pkt_len <= pkt_len + LEN_W'(1);
            else                   pkt_err <= 1'b1;
            if (snk_sop) pkt_err <= 1'b1;
            if (snk_eop) begin
              state    <= DONE;
              snk_done <= 1'b1;
            end
          end else if (expire) begin
            state    <= DONE;
            snk_done <= 1'b1;
            pkt_err  <= 1'b1;
          end
        end
        DONE: begin
          if (!src_ready) begin
            state    <= WAIT_DS;
            snk_done <= 1'b0;
          end
        end
        WAIT_DS: begin
          if (src_ready) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          snk_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snk_packet_writer.sv
// Scenario bench for snk_packet_writer with MAX_LENGTH=16, TIMEOUT=8.
// Expected FIFO writes are queued by each scenario and matched in order as they appear.
module tb_snk_packet_writer;

  localparam int DW = 8;
  localparam int ML = 16;
  localparam int TO = 8;

  logic          src_clock = 1'b0;
  logic          src_reset = 1'b1;
  logic          snk_valid = 1'b0;
  logic          snk_sop   = 1'b0;
  logic          snk_eop   = 1'b0;
  logic [DW-1:0] snk_data  = '0;
  logic          snk_ready;
  logic          fifo_full = 1'b0;
  logic          wr_fifo;
  logic [DW-1:0] fifo_wdata;
  logic          src_ready = 1'b1;
  logic          snk_done;
  logic [4:0]    pkt_len;
  logic          pkt_err;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int wr_count  = 0;
  logic [DW-1:0] exp_q[$];

  snk_packet_writer #(
    .DATA_WIDTH (DW),
    .MAX_LENGTH (ML),
    .TIMEOUT    (TO)
  ) dut (
    .src_clock  (src_clock),
    .src_reset  (src_reset),
    .snk_valid  (snk_valid),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .snk_data   (snk_data),
    .snk_ready  (snk_ready),
    .fifo_full  (fifo_full),
    .wr_fifo    (wr_fifo),
    .fifo_wdata (fifo_wdata),
    .src_ready  (src_ready),
    .snk_done   (snk_done),
    .pkt_len    (pkt_len),
    .pkt_err    (pkt_err)
  );

  always #5 src_clock = ~src_clock;

  // Scoreboard: every FIFO write must match the oldest queued expectation.
  always @(negedge src_clock) begin
    if (wr_fifo) begin
      wr_count++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got data %h, no write expected", fifo_wdata);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (fifo_wdata !== e) $display("FAIL sb_data: got %h, expected %h", fifo_wdata, e);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", check_cnt);
    $fatal(1, "watchdog");
  end

  // Presents one word from posedge+1 and returns at posedge+1 after it is accepted.
  task automatic drive_word(input logic [DW-1:0] d, input logic sop, input logic eop);
    int n;
    snk_valid = 1'b1; snk_sop = sop; snk_eop = eop; snk_data = d;
    n = 0;
    @(negedge src_clock);
    while (!snk_ready && n < 200) begin
      n++;
      @(negedge src_clock);
    end
    if (!snk_ready) begin
      check_cnt++;
      $display("FAIL ready_timeout: snk_ready stayed %b, expected 1 within 200 cycles", snk_ready);
    end
    @(posedge src_clock); #1;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  // Walks the handshake DONE -> WAIT_DS -> IDLE.
  task automatic release_ds();
    src_ready = 1'b0;
    repeat (2) @(posedge src_clock);
    #1 src_ready = 1'b1;
    @(posedge src_clock); #1;
  endtask

  task automatic test_reset();
    src_reset = 1'b1;
    #3;
    check_cnt++;
    if ({snk_ready, wr_fifo, snk_done, pkt_len, pkt_err} !== 9'b0)
      $display("FAIL reset_outputs: got rdy=%b wr=%b done=%b len=%0d err=%b, expected all 0",
               snk_ready, wr_fifo, snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    @(posedge src_clock); #1 src_reset = 1'b0;
    @(negedge src_clock);
    check_cnt++;
    if (snk_ready !== 1'b1) $display("FAIL idle_ready: got %b, expected 1", snk_ready);
    else pass_cnt++;
    @(posedge src_clock); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int base;
    base = wr_count;
    foreach (w[i]) exp_q.push_back(w[i]);
    foreach (w[i]) drive_word(w[i], i == 0, i == 3);
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, snk_ready, pkt_len, pkt_err} !== {1'b1, 1'b0, 5'd4, 1'b0})
      $display("FAIL basic_done: got done=%b rdy=%b len=%0d err=%b, expected 1 0 4 0",
               snk_done, snk_ready, pkt_len, pkt_err);
    else pass_cnt++;
    check_cnt++;
    if (wr_count - base !== 4) $display("FAIL basic_writes: got %0d, expected 4", wr_count - base);
    else pass_cnt++;
    release_ds();
  endtask

  task automatic test_single();
    exp_q.push_back(8'h5A);
    drive_word(8'h5A, 1'b1, 1'b1);
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, pkt_len, pkt_err} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL single_done: got done=%b len=%0d err=%b, expected 1 1 0", snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    release_ds();
  endtask

  task automatic test_overlength();
    int base;
    base = wr_count;
    for (int i = 0; i < ML; i++) exp_q.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 20; i++) drive_word(8'h80 + 8'(i), i == 0, i == 19);
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, pkt_len, pkt_err} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL overlength_done: got done=%b len=%0d err=%b, expected 1 16 1", snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    check_cnt++;
    if (wr_count - base !== 16) $display("FAIL overlength_writes: got %0d, expected 16", wr_count - base);
    else pass_cnt++;
    release_ds();
  endtask

  task automatic test_handshake();
    int bad;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    drive_word(8'h61, 1'b1, 1'b0);
    drive_word(8'h62, 1'b0, 1'b1);
    bad = 0;
    repeat (5) begin
      @(negedge src_clock);
      if (snk_done !== 1'b1) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL hold_done: snk_done low in %0d of 5 cycles, expected high", bad);
    else pass_cnt++;
    @(posedge src_clock); #1;
    src_ready = 1'b0;
    snk_valid = 1'b1; snk_sop = 1'b1; snk_eop = 1'b0; snk_data = 8'hA1;
    bad = 0;
    @(posedge src_clock);
    repeat (10) begin
      @(negedge src_clock);
      if (snk_ready !== 1'b0 || snk_done !== 1'b0) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL wait_ds: ready/done high in %0d of 10 cycles, expected 0", bad);
    else pass_cnt++;
    @(posedge src_clock); #1;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    src_ready = 1'b1;
    drive_word(8'hA1, 1'b1, 1'b0);
    drive_word(8'hA2, 1'b0, 1'b1);
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, pkt_len, pkt_err} !== {1'b1, 5'd2, 1'b0})
      $display("FAIL second_pkt: got done=%b len=%0d err=%b, expected 1 2 0", snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    release_ds();
  endtask

  task automatic test_framing_timeout();
    int base, bad;
    base = wr_count;
    drive_word(8'h77, 1'b0, 1'b0);
    @(negedge src_clock);
    check_cnt++;
    if (wr_count != base || snk_done !== 1'b0)
      $display("FAIL no_sop_drop: got writes=%0d done=%b, expected 0 0", wr_count - base, snk_done);
    else pass_cnt++;
    @(posedge src_clock); #1;
    exp_q.push_back(8'hC1);
    drive_word(8'hC1, 1'b1, 1'b0);
    bad = 0;
    repeat (TO) begin
      @(negedge src_clock);
      if (snk_done !== 1'b0) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL timeout_early: done high in %0d of %0d idle cycles, expected 0", bad, TO);
    else pass_cnt++;
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, pkt_len, pkt_err} !== {1'b1, 5'd1, 1'b1})
      $display("FAIL timeout_done: got done=%b len=%0d err=%b, expected 1 1 1", snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    @(posedge src_clock); #1;
    release_ds();
  endtask

  task automatic test_fifo_full();
    int bad;
    logic [DW-1:0] w[4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    foreach (w[i]) exp_q.push_back(w[i]);
    drive_word(w[0], 1'b1, 1'b0);
    drive_word(w[1], 1'b0, 1'b0);
    fifo_full = 1'b1;
    snk_valid = 1'b1; snk_data = w[2];
    bad = 0;
    repeat (4) begin
      @(negedge src_clock);
      if (snk_ready !== 1'b0 || wr_fifo !== 1'b0) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL full_stall: ready/write high in %0d of 4 cycles, expected 0", bad);
    else pass_cnt++;
    @(posedge src_clock); #1;
    fifo_full = 1'b0;
    drive_word(w[2], 1'b0, 1'b0);
    drive_word(w[3], 1'b0, 1'b1);
    @(negedge src_clock);
    check_cnt++;
    if ({snk_done, pkt_len, pkt_err} !== {1'b1, 5'd4, 1'b0})
      $display("FAIL full_done: got done=%b len=%0d err=%b, expected 1 4 0", snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    release_ds();
  endtask

  task automatic test_reset_mid();
    int base;
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hE2);
    drive_word(8'hE1, 1'b1, 1'b0);
    drive_word(8'hE2, 1'b0, 1'b0);
    snk_valid = 1'b1; snk_data = 8'hE3;
    #2 src_reset = 1'b1;
    #1;
    check_cnt++;
    if ({snk_ready, wr_fifo, snk_done, pkt_len, pkt_err} !== 9'b0)
      $display("FAIL mid_reset: got rdy=%b wr=%b done=%b len=%0d err=%b, expected all 0",
               snk_ready, wr_fifo, snk_done, pkt_len, pkt_err);
    else pass_cnt++;
    snk_valid = 1'b0;
    @(posedge src_clock); #1 src_reset = 1'b0;
    base = wr_count;
    drive_word(8'hE4, 1'b0, 1'b0);
    @(negedge src_clock);
    check_cnt++;
    if (wr_count != base || snk_done !== 1'b0)
      $display("FAIL post_reset_idle: got writes=%0d done=%b, expected 0 0", wr_count - base, snk_done);
    else pass_cnt++;
    @(posedge src_clock); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overlength();
    test_handshake();
    test_framing_timeout();
    test_fifo_full();
    test_reset_mid();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d writes missing, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
